// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//
// Shared definitions for the instruction-fetch sequencer:
//   - fetch_state_t : FSM state encoding (IDLE=0 ... ERR=6)
//   - WORDS_MAX_LO / WORDS_MAX_HI : legal range of the instruction length
//   - clamp_words_max() : folds an out-of-range WORDS_MAX back into range
// -----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_READ  = 3'd2,
        S_LATCH = 3'd3,
        S_INC   = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } fetch_state_t;

    localparam int WORDS_MAX_LO = 1;
    localparam int WORDS_MAX_HI = 8;

    // Keeps the word-count saturation inside the supported range so a
    // misconfigured WORDS_MAX can never ask for more IR words than exist.
    function automatic int clamp_words_max(input int w);
        if (w < WORDS_MAX_LO) return WORDS_MAX_LO;
        if (w > WORDS_MAX_HI) return WORDS_MAX_HI;
        return w;
    endfunction

endpackage

// File: rtl/fetch_wait_timer.sv
// -----------------------------------------------------------------------------
// fetch_wait_timer
//
// Counts cycles spent waiting for MFC on the current memory word.
//
// Ports:
//   clk     in  : system clock, rising edge
//   rst_n   in  : asynchronous active-low reset
//   clear   in  : synchronous clear of the wait count
//   enable  in  : count this cycle (waiting, no MFC yet)
//   expired out : high when the count will reach TIMEOUT at the next edge
//
// TIMEOUT = 0 disables expiry; the counter then collapses to a single bit.
// -----------------------------------------------------------------------------
module fetch_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [CNT_W-1:0] count;

    // Wait counter: cleared while the address phase is active, so every word
    // starts its READ wait from zero. It saturates rather than wrapping so a
    // disabled timeout can never alias back to a small count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

    // Expiry is flagged in the cycle whose increment would make the count
    // equal TIMEOUT, so the FSM leaves READ after exactly TIMEOUT waits.
    generate
        if (TIMEOUT == 0) begin : g_no_timeout
            assign expired = 1'b0;
        end else begin : g_timeout
            assign expired = enable && (count == CNT_W'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/fetch_seq.sv
// -----------------------------------------------------------------------------
// fetch_seq
//
// Multi-word instruction-fetch sequencer. Walks ADDR -> READ -> LATCH -> INC
// once per instruction word, then pulses fetch_done (or fetch_err on an MFC
// timeout). All control strobes are Moore outputs of the state register.
//
// Ports:
//   clk, rst_n   in  : clock (rising edge), async active-low reset
//   start        in  : begin a fetch, only looked at in IDLE
//   abort        in  : return to IDLE from any busy state at the next edge
//   mfc          in  : memory function complete
//   ext_words    in  : extra words beyond word 0, decoded from IR word 0
//   busy         out : sequencer not in IDLE
//   pc_out_en    out : PC drives bus
//   mar_in       out : MAR loads from bus
//   mem_en       out : memory enable
//   mem_rw       out : memory read (1) / write (0)
//   mdr_out_en   out : MDR drives bus
//   ir_in        out : one-hot IR word load strobe
//   pc_inc       out : PC increment strobe
//   fetch_done   out : one-cycle pulse, instruction complete
//   fetch_err    out : one-cycle pulse, MFC timeout
// -----------------------------------------------------------------------------
module fetch_seq
    import fetch_pkg::*;
#(
    parameter int WORDS_MAX = 2,
    parameter int TIMEOUT   = 15
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          start,
    input  logic                                          abort,
    input  logic                                          mfc,
    input  logic [((WORDS_MAX > 1) ? $clog2(WORDS_MAX) : 1)-1:0] ext_words,
    output logic                                          busy,
    output logic                                          pc_out_en,
    output logic                                          mar_in,
    output logic                                          mem_en,
    output logic                                          mem_rw,
    output logic                                          mdr_out_en,
    output logic [WORDS_MAX-1:0]                          ir_in,
    output logic                                          pc_inc,
    output logic                                          fetch_done,
    output logic                                          fetch_err
);

    localparam int IDX_W  = (WORDS_MAX > 1) ? $clog2(WORDS_MAX) : 1;
    localparam int NEED_W = $clog2(WORDS_MAX + 1);
    localparam int WM     = clamp_words_max(WORDS_MAX);

    fetch_state_t      state, state_next;
    logic [IDX_W-1:0]  word_idx, word_idx_next;
    logic [NEED_W-1:0] words_needed, words_needed_next;
    logic [NEED_W-1:0] words_decoded;
    logic [NEED_W-1:0] words_eff;
    logic              last_word;
    logic              wait_expired;

    fetch_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state == S_ADDR),
        .enable  ((state == S_READ) && !mfc),
        .expired (wait_expired)
    );

    // Instruction length from word 0: one word plus the decoded extension,
    // saturated at the number of IR words actually implemented.
    always_comb begin
        words_decoded = NEED_W'(WM);
        if (int'(ext_words) + 1 < WM) begin
            words_decoded = NEED_W'(int'(ext_words) + 1);
        end
    end

    // In INC of word 0 the freshly decoded length must drive the decision,
    // since words_needed only picks it up at the same edge.
    assign words_eff = (word_idx == '0) ? words_decoded : words_needed;
    assign last_word = !(int'(word_idx) + 1 < int'(words_eff));

    // State, word index and instruction-length registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            word_idx     <= '0;
            words_needed <= NEED_W'(1);
        end else begin
            state        <= state_next;
            word_idx     <= word_idx_next;
            words_needed <= words_needed_next;
        end
    end

    // Next-state logic. Abort wins over everything in a busy state; in IDLE
    // it is ignored so a simultaneous start still launches a fetch. ADDR
    // holds while MFC is still high from the previous access so a stale
    // acknowledge cannot complete the new read.
    always_comb begin
        state_next        = state;
        word_idx_next     = word_idx;
        words_needed_next = words_needed;

        if (abort && (state != S_IDLE)) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_next        = S_ADDR;
                        word_idx_next     = '0;
                        words_needed_next = NEED_W'(1);
                    end
                end
                S_ADDR: begin
                    if (!mfc) state_next = S_READ;
                end
                S_READ: begin
                    if (mfc)               state_next = S_LATCH;
                    else if (wait_expired) state_next = S_ERR;
                end
                S_LATCH: state_next = S_INC;
                S_INC: begin
                    if (word_idx == '0) words_needed_next = words_decoded;
                    if (last_word) begin
                        state_next = S_DONE;
                    end else begin
                        state_next    = S_ADDR;
                        word_idx_next = word_idx + IDX_W'(1);
                    end
                end
                S_DONE:  state_next = S_IDLE;
                S_ERR:   state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Moore output decode; the IR strobe is steered by the current word.
    always_comb begin
        busy       = (state != S_IDLE);
        pc_out_en  = 1'b0;
        mar_in     = 1'b0;
        mem_en     = 1'b0;
        mem_rw     = 1'b0;
        mdr_out_en = 1'b0;
        ir_in      = '0;
        pc_inc     = 1'b0;
        fetch_done = 1'b0;
        fetch_err  = 1'b0;
        case (state)
            S_ADDR: begin
                pc_out_en = 1'b1;
                mar_in    = 1'b1;
            end
            S_READ: begin
                mem_en = 1'b1;
                mem_rw = 1'b1;
            end
            S_LATCH: begin
                mdr_out_en = 1'b1;
                ir_in      = WORDS_MAX'(1) << word_idx;
            end
            S_INC:   pc_inc     = 1'b1;
            S_DONE:  fetch_done = 1'b1;
            S_ERR:   fetch_err  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fetch_seq.sv
// -----------------------------------------------------------------------------
// tb_fetch_seq
//
// Directed testbench for fetch_seq (WORDS_MAX=2, TIMEOUT=15). Inputs change
// 1 ns after each rising edge and outputs are compared at that point, so the
// value seen after the n-th edge following start is "cycle n".
// Output vector bit order:
//   busy pc_out_en mar_in mem_en mem_rw mdr_out_en ir_in[1:0] pc_inc done err
// -----------------------------------------------------------------------------
module tb_fetch_seq;

    localparam logic [10:0] O_IDLE   = 11'b00000000000;
    localparam logic [10:0] O_ADDR   = 11'b11100000000;
    localparam logic [10:0] O_READ   = 11'b10011000000;
    localparam logic [10:0] O_LATCH0 = 11'b10000101000;
    localparam logic [10:0] O_LATCH1 = 11'b10000110000;
    localparam logic [10:0] O_INC    = 11'b10000000100;
    localparam logic [10:0] O_DONE   = 11'b10000000010;
    localparam logic [10:0] O_ERR    = 11'b10000000001;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       mfc;
    logic [0:0] ext_words;
    logic       busy, pc_out_en, mar_in, mem_en, mem_rw, mdr_out_en;
    logic [1:0] ir_in;
    logic       pc_inc, fetch_done, fetch_err;

    logic [10:0] outs;
    int total = 0;
    int bad   = 0;

    assign outs = {busy, pc_out_en, mar_in, mem_en, mem_rw, mdr_out_en,
                   ir_in, pc_inc, fetch_done, fetch_err};

    fetch_seq #(
        .WORDS_MAX (2),
        .TIMEOUT   (15)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .mfc        (mfc),
        .ext_words  (ext_words),
        .busy       (busy),
        .pc_out_en  (pc_out_en),
        .mar_in     (mar_in),
        .mem_en     (mem_en),
        .mem_rw     (mem_rw),
        .mdr_out_en (mdr_out_en),
        .ir_in      (ir_in),
        .pc_inc     (pc_inc),
        .fetch_done (fetch_done),
        .fetch_err  (fetch_err)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Advance one cycle and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Outputs must be zero while reset is held, including across clock edges.
    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mfc = 1'b0; ext_words = 1'b0;
        #3;
        total++;
        if (outs !== O_IDLE) begin
            bad++;
            $display("[TB] FAIL reset_initial got=%b want=%b", outs, O_IDLE);
        end
        start = 1'b1;
        step();
        step();
        total++;
        if (outs !== O_IDLE) begin
            bad++;
            $display("[TB] FAIL reset_held got=%b want=%b", outs, O_IDLE);
        end
        start = 1'b0;
        rst_n = 1'b1;
        step();
        total++;
        if (outs !== O_IDLE) begin
            bad++;
            $display("[TB] FAIL reset_release got=%b want=%b", outs, O_IDLE);
        end
    endtask

    // One word, MFC in the first READ cycle: done pulses at cycle 5.
    task automatic test_single_word();
        logic [10:0] exp_tbl [6];
        bit          mfc_tbl [6];
        exp_tbl = '{O_ADDR, O_READ, O_LATCH0, O_INC, O_DONE, O_IDLE};
        mfc_tbl = '{0, 1, 0, 0, 0, 0};
        ext_words = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (outs !== exp_tbl[i]) begin
                bad++;
                $display("[TB] FAIL single_word cyc=%0d got=%b want=%b", i + 1, outs, exp_tbl[i]);
            end
            mfc = mfc_tbl[i];
            step();
        end
    endtask

    // Two words, two MFC wait cycles per word: 5 + 2 + 4 + 2 gives done at 13.
    task automatic test_two_words();
        logic [10:0] exp_tbl [14];
        bit          mfc_tbl [14];
        int          inc_cnt;
        exp_tbl = '{O_ADDR, O_READ, O_READ, O_READ, O_LATCH0, O_INC,
                    O_ADDR, O_READ, O_READ, O_READ, O_LATCH1, O_INC,
                    O_DONE, O_IDLE};
        mfc_tbl = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
        inc_cnt = 0;
        ext_words = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 14; i++) begin
            total++;
            if (outs !== exp_tbl[i]) begin
                bad++;
                $display("[TB] FAIL two_words cyc=%0d got=%b want=%b", i + 1, outs, exp_tbl[i]);
            end
            if (pc_inc === 1'b1) inc_cnt++;
            mfc = mfc_tbl[i];
            step();
        end
        total++;
        if (inc_cnt != 2) begin
            bad++;
            $display("[TB] FAIL two_words_pc_inc got=%0d want=2", inc_cnt);
        end
        ext_words = 1'b0;
    endtask

    // MFC still high when ADDR is entered holds ADDR until MFC drops.
    task automatic test_stale_mfc();
        logic [10:0] exp_tbl [8];
        bit          mfc_tbl [8];
        exp_tbl = '{O_ADDR, O_ADDR, O_ADDR, O_READ, O_LATCH0, O_INC, O_DONE, O_IDLE};
        mfc_tbl = '{1, 1, 0, 1, 0, 0, 0, 0};
        ext_words = 1'b0;
        mfc = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (outs !== exp_tbl[i]) begin
                bad++;
                $display("[TB] FAIL stale_mfc cyc=%0d got=%b want=%b", i + 1, outs, exp_tbl[i]);
            end
            mfc = mfc_tbl[i];
            step();
        end
    endtask

    // No MFC: 15 READ cycles (2..16), ERR at 17, IDLE at 18, PC never bumped.
    task automatic test_timeout();
        logic [10:0] want;
        int          inc_cnt;
        inc_cnt = 0;
        mfc = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            if (c == 1)       want = O_ADDR;
            else if (c <= 16) want = O_READ;
            else if (c == 17) want = O_ERR;
            else              want = O_IDLE;
            total++;
            if (outs !== want) begin
                bad++;
                $display("[TB] FAIL timeout cyc=%0d got=%b want=%b", c, outs, want);
            end
            if (pc_inc === 1'b1) inc_cnt++;
            step();
        end
        total++;
        if (inc_cnt != 0) begin
            bad++;
            $display("[TB] FAIL timeout_pc_inc got=%0d want=0", inc_cnt);
        end
    endtask

    // Abort during the READ of word 1: straight to IDLE, one pc_inc, no done.
    task automatic test_abort();
        logic [10:0] exp_tbl [8];
        bit          mfc_tbl [8];
        bit          abt_tbl [8];
        int          inc_cnt;
        int          done_cnt;
        exp_tbl = '{O_ADDR, O_READ, O_LATCH0, O_INC, O_ADDR, O_READ, O_IDLE, O_IDLE};
        mfc_tbl = '{0, 1, 0, 0, 0, 0, 0, 0};
        abt_tbl = '{0, 0, 0, 0, 0, 1, 0, 0};
        inc_cnt = 0;
        done_cnt = 0;
        ext_words = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (outs !== exp_tbl[i]) begin
                bad++;
                $display("[TB] FAIL abort cyc=%0d got=%b want=%b", i + 1, outs, exp_tbl[i]);
            end
            if (pc_inc === 1'b1) inc_cnt++;
            if (fetch_done === 1'b1) done_cnt++;
            mfc = mfc_tbl[i];
            abort = abt_tbl[i];
            step();
        end
        abort = 1'b0;
        total++;
        if (inc_cnt != 1 || done_cnt != 0) begin
            bad++;
            $display("[TB] FAIL abort_counts got=inc%0d/done%0d want=inc1/done0", inc_cnt, done_cnt);
        end
        ext_words = 1'b0;
    endtask

    // start held through the whole fetch is ignored while busy and picked up
    // in the IDLE cycle after DONE; start+abort in IDLE starts; abort in ADDR
    // returns to IDLE.
    task automatic test_back_to_back();
        logic [10:0] exp_tbl [8];
        bit          mfc_tbl [8];
        bit          sta_tbl [8];
        bit          abt_tbl [8];
        exp_tbl = '{O_ADDR, O_READ, O_LATCH0, O_INC, O_DONE, O_IDLE, O_ADDR, O_IDLE};
        mfc_tbl = '{0, 1, 0, 0, 0, 0, 0, 0};
        sta_tbl = '{1, 1, 1, 1, 1, 1, 0, 0};
        abt_tbl = '{0, 0, 0, 0, 0, 1, 1, 0};
        ext_words = 1'b0;
        start = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            total++;
            if (outs !== exp_tbl[i]) begin
                bad++;
                $display("[TB] FAIL back_to_back cyc=%0d got=%b want=%b", i + 1, outs, exp_tbl[i]);
            end
            mfc = mfc_tbl[i];
            start = sta_tbl[i];
            abort = abt_tbl[i];
            step();
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    // Reset asserted mid-READ clears outputs at once; the next fetch restarts
    // cleanly at word 0.
    task automatic test_reset_mid_read();
        logic [10:0] exp_tbl [6];
        bit          mfc_tbl [6];
        exp_tbl = '{O_ADDR, O_READ, O_LATCH0, O_INC, O_DONE, O_IDLE};
        mfc_tbl = '{0, 1, 0, 0, 0, 0};
        ext_words = 1'b1;
        mfc = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        total++;
        if (outs !== O_READ) begin
            bad++;
            $display("[TB] FAIL mid_read_pre got=%b want=%b", outs, O_READ);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (outs !== O_IDLE) begin
            bad++;
            $display("[TB] FAIL mid_read_async got=%b want=%b", outs, O_IDLE);
        end
        step();
        rst_n = 1'b1;
        ext_words = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (outs !== exp_tbl[i]) begin
                bad++;
                $display("[TB] FAIL mid_read_refetch cyc=%0d got=%b want=%b", i + 1, outs, exp_tbl[i]);
            end
            mfc = mfc_tbl[i];
            step();
        end
    endtask

    // Scenario sequence.
    initial begin
        test_reset();
        test_single_word();
        test_two_words();
        test_stale_mfc();
        test_timeout();
        test_abort();
        test_back_to_back();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net against a stalled simulation.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=expired want=finished");
        $fatal(1, "[TB] watchdog");
    end

endmodule
